// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer that sits directly in front of the UART transmitter. The
// register interface writes bytes into a small circular FIFO. Bytes are
// launched into the transmitter one at a time over the tx_en / tx_busy
// handshake, so the CPU can queue several bytes without polling busy between
// each.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   PAYLOAD_BITS byte width, must match the transmitter
//
// Ports
//   clk      in   system clock
//   resetn   in   synchronous active-low reset
//   wr_en    in   write strobe, one byte per cycle
//   wr_data  in   byte to queue
//   flush    in   discard all queued bytes
//   clr_ovf  in   clear the sticky overflow flag
//   full     out  FIFO holds DEPTH bytes
//   empty    out  FIFO holds no bytes
//   level    out  number of queued bytes
//   overflow out  sticky: a write was dropped because the FIFO was full
//   tx_en    out  single-cycle launch strobe to the transmitter
//   tx_data  out  byte to transmit, valid while tx_en is high
//   tx_busy  in   transmitter busy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH        = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      wr_en,
    input  logic [PAYLOAD_BITS-1:0]   wr_data,
    input  logic                      flush,
    input  logic                      clr_ovf,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      tx_en,
    output logic [PAYLOAD_BITS-1:0]   tx_data,
    input  logic                      tx_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             launched_q, launched_d;
    logic             overflow_q, overflow_d;
    logic             wr_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign overflow = overflow_q;

    // launched_q masks the single cycle between our strobe and the
    // transmitter raising busy, so tx_en can never fire on adjacent cycles.
    assign tx_en   = !empty && !tx_busy && !launched_q && !flush;
    assign tx_data = mem[rd_ptr_q];

    always_comb begin
        wr_ok      = wr_en && !full && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        launched_d = tx_en;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (tx_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Fullness is judged on the current count, so a write into a
            // full FIFO is dropped even if a pop happens in the same cycle.
            case ({wr_ok, tx_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Set has priority over clear so a simultaneous drop is not lost.
        if (wr_en && full && !flush) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            launched_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            launched_q <= launched_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed and randomized bench for uart_tx_fifo. The reference model keeps
// the queued bytes in a SystemVerilog queue plus the launch and overflow
// flags, and a simple transmitter model drives tx_busy after each launch.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int PB    = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [PB-1:0] wr_data;
    logic          flush;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic [2:0]    level;
    logic          overflow;
    logic          tx_en;
    logic [PB-1:0] tx_data;
    logic          tx_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .PAYLOAD_BITS(PB)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    byte unsigned q[$];
    bit           m_launched;
    bit           m_ovf;

    // Transmitter model
    bit auto_tx;
    int busy_len;
    int busy_cnt;

    bit           prev_tx_en;
    byte unsigned log_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_tx_en();
        return (q.size() != 0) && !tx_busy && !m_launched && !flush;
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model.
    task automatic cyc();
        bit e;
        bit was_full;
        @(negedge clk);
        e = model_tx_en();
        chk("tx_en", tx_en, e);
        chk("level", level, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        if (e) chk("tx_data", tx_data, q[0]);
        chk("no_adjacent_tx_en", tx_en & prev_tx_en, 1'b0);
        prev_tx_en = (tx_en === 1'b1);
        if (tx_en === 1'b1) log_q.push_back(tx_data);

        @(posedge clk);
        was_full = (q.size() == DEPTH);
        if (!resetn) begin
            q.delete();
            m_launched = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                if (e) void'(q.pop_front());
                if (wr_en && !was_full) q.push_back(wr_data);
            end
            if (wr_en && was_full && !flush) m_ovf = 1'b1;
            else if (clr_ovf)                m_ovf = 1'b0;
            m_launched = e;
        end
        #1;
        if (auto_tx) begin
            if (e) busy_cnt = busy_len;
            if (busy_cnt > 0) begin
                tx_busy = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    endtask

    task automatic check_log(input string tag, input byte unsigned exp[$]);
        chk({tag, "_count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < log_q.size()) chk(tag, log_q[i], exp[i]);
        end
    endtask

    initial begin
        byte unsigned e[$];
        int n;

        resetn   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        clr_ovf  = 1'b0;
        tx_busy  = 1'b0;
        auto_tx  = 1'b0;
        busy_len = 1;
        busy_cnt = 0;
        prev_tx_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn     = 1'b1;
        q.delete();
        m_launched = 1'b0;
        m_ovf      = 1'b0;

        // Reset state
        chk("reset_empty", empty, 1'b1);
        chk("reset_full", full, 1'b0);
        chk("reset_level", level, 3'd0);
        chk("reset_tx_en", tx_en, 1'b0);
        chk("reset_overflow", overflow, 1'b0);

        // Single byte: tx_en exactly one cycle after the write
        log_q.delete();
        wr_en = 1'b1; wr_data = 8'h55; cyc();
        wr_en = 1'b0;
        chk("single_tx_en_n1", tx_en, 1'b1);
        chk("single_tx_data", tx_data, 8'h55);
        cyc();
        chk("single_tx_en_n2", tx_en, 1'b0);
        chk("single_empty", empty, 1'b1);
        chk("single_level", level, 3'd0);
        repeat (2) cyc();
        e = '{8'h55};
        check_log("single_log", e);

        // Queue burst while transmitter busy
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'((i + 1) * 8'h11); cyc();
        end
        wr_en = 1'b0;
        chk("burst_full", full, 1'b1);
        chk("burst_level", level, 3'd4);
        chk("burst_tx_en", tx_en, 1'b0);
        cyc();

        // Overflow while full, clear, and set-wins
        wr_en = 1'b1; wr_data = 8'h99; cyc();
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_level", level, 3'd4);
        clr_ovf = 1'b1; cyc();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        clr_ovf = 1'b1; wr_en = 1'b1; wr_data = 8'h99; cyc();
        clr_ovf = 1'b0; wr_en = 1'b0;
        chk("ovf_set_wins", overflow, 1'b1);
        clr_ovf = 1'b1; cyc();
        clr_ovf = 1'b0;

        // Drain with transmitter busy for one cycle after each launch
        log_q.delete();
        auto_tx = 1'b1; busy_len = 1; busy_cnt = 0; tx_busy = 1'b0;
        repeat (20) cyc();
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_log("burst_order", e);

        // Simultaneous write and pop
        auto_tx = 1'b0; tx_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'hAA; cyc();
        wr_data = 8'hBB; cyc();
        log_q.delete();
        wr_data = 8'hAB; tx_busy = 1'b0; cyc();
        wr_en = 1'b0; tx_busy = 1'b1;
        chk("simul_level", level, 3'd2);
        cyc();
        auto_tx = 1'b1; busy_len = 2; busy_cnt = 0; tx_busy = 1'b0;
        repeat (20) cyc();
        e = '{8'hAA, 8'hBB, 8'hAB};
        check_log("simul_order", e);

        // Flush with a concurrent write while a launch would otherwise occur
        auto_tx = 1'b0; tx_busy = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hC1; cyc();
        wr_data = 8'hC2; cyc();
        wr_data = 8'hC3; cyc();
        chk("flush_pre_level", level, 3'd3);
        log_q.delete();
        tx_busy = 1'b0; flush = 1'b1; wr_data = 8'hDD;
        cyc();
        flush = 1'b0; wr_en = 1'b0;
        chk("flush_level", level, 3'd0);
        chk("flush_empty", empty, 1'b1);
        repeat (5) cyc();
        chk("flush_no_tx", log_q.size(), 0);

        // Wrap-around: ten bytes through the four-entry FIFO
        log_q.delete();
        auto_tx = 1'b1; busy_len = 1; busy_cnt = 0; tx_busy = 1'b0;
        n = 0;
        e.delete();
        for (int i = 0; i < 10; i++) e.push_back(8'(i));
        for (int i = 0; i < 60; i++) begin
            if (n < 10 && q.size() < DEPTH) begin
                wr_en = 1'b1; wr_data = 8'(n); n++;
            end else begin
                wr_en = 1'b0;
            end
            cyc();
            if (level > 3'd4) chk("wrap_level_bound", level, 3'd4);
        end
        wr_en = 1'b0;
        check_log("wrap_order", e);

        // Randomized traffic including one mid-operation reset
        for (int i = 0; i < 400; i++) begin
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_data  = 8'($urandom);
            flush    = ($urandom_range(0, 31) == 0);
            clr_ovf  = ($urandom_range(0, 15) == 0);
            busy_len = $urandom_range(0, 3);
            resetn   = (i != 200);
            cyc();
        end
        wr_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0; resetn = 1'b1;
        repeat (30) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
